// File: rtl/ramb4_s8_port_master.sv
// ramb4_s8_port_master
// Burst controller for a 512x8 single-port synchronous block RAM.
// Write bursts move a valid/ready byte stream into the RAM. Read bursts
// stream RAM bytes out through a 2-entry buffer that absorbs the RAM's
// one-cycle read latency, so downstream backpressure never drops or
// duplicates a byte.
module ramb4_s8_port_master #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WRITE,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [ADDR_W-1:0] CMD_LEN,
  input  logic              WR_VALID,
  output logic              WR_READY,
  input  logic [DATA_W-1:0] WR_DATA,
  output logic              RD_VALID,
  input  logic              RD_READY,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              RD_LAST,
  output logic              BUSY,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [DATA_W-1:0] RAM_DI,
  output logic              RAM_EN,
  output logic              RAM_WE,
  output logic              RAM_RST,
  input  logic [DATA_W-1:0] RAM_DO
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              cmd_ready_q;
  // Next RAM address to access; wraps naturally at 2^ADDR_W.
  logic [ADDR_W-1:0] addr_q, addr_d;
  // Bytes left after the current one (write) or reads left to issue (read).
  logic [ADDR_W-1:0] rem_q, rem_d;
  // All reads of the burst have been issued.
  logic              iss_done_q, iss_done_d;
  // A read was issued last cycle, so RAM_DO carries its byte this cycle.
  logic              out_q, out_d;
  logic              out_last_q, out_last_d;
  // Two-entry output buffer: data plus end-of-burst marker.
  logic [DATA_W-1:0] buf_data_q [2];
  logic [DATA_W-1:0] buf_data_d [2];
  logic              buf_last_q [2];
  logic              buf_last_d [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        cnt_q, cnt_d;

  logic              wr_fire;
  logic              rd_pop;
  logic              rd_issue;
  logic [1:0]        occ_after_pop;

  assign wr_fire       = (state_q == S_WRITE) && WR_VALID;
  assign rd_pop        = (cnt_q != 2'd0) && RD_READY;
  // Slots committed once this cycle's pop is taken into account.
  assign occ_after_pop = cnt_q - {1'b0, rd_pop} + {1'b0, out_q};
  assign rd_issue      = (state_q == S_READ) && !iss_done_q && (occ_after_pop < 2'd2);

  assign CMD_READY = cmd_ready_q;
  assign WR_READY  = (state_q == S_WRITE);
  assign RD_VALID  = (cnt_q != 2'd0);
  assign RD_DATA   = buf_data_q[rd_ptr_q];
  assign RD_LAST   = RD_VALID && buf_last_q[rd_ptr_q];
  assign BUSY      = (state_q != S_IDLE);
  // The RAM port is kept quiet during a reset cycle even mid-burst.
  assign RAM_EN    = RST && (wr_fire || rd_issue);
  assign RAM_WE    = RST && wr_fire;
  assign RAM_ADDR  = addr_q;
  assign RAM_DI    = (state_q == S_WRITE) ? WR_DATA : '0;
  assign RAM_RST   = 1'b0;

  // Next-state logic for command acceptance, burst counters and the read buffer.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    iss_done_d = iss_done_q;
    out_d      = 1'b0;
    out_last_d = 1'b0;
    buf_data_d = buf_data_q;
    buf_last_d = buf_last_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (CMD_VALID && cmd_ready_q) begin
          addr_d     = CMD_ADDR;
          rem_d      = CMD_LEN;
          iss_done_d = 1'b0;
          state_d    = CMD_WRITE ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        if (wr_fire) begin
          addr_d = addr_q + ADDR_W'(1);
          if (rem_q == '0) state_d = S_IDLE;
          else             rem_d   = rem_q - ADDR_W'(1);
        end
      end
      S_READ: begin
        if (rd_issue) begin
          addr_d     = addr_q + ADDR_W'(1);
          out_d      = 1'b1;
          out_last_d = (rem_q == '0);
          if (rem_q == '0) iss_done_d = 1'b1;
          else             rem_d      = rem_q - ADDR_W'(1);
        end
        // RAM_DO is only meaningful the cycle after an issue.
        if (out_q) begin
          buf_data_d[wr_ptr_q] = RAM_DO;
          buf_last_d[wr_ptr_q] = out_last_q;
          wr_ptr_d             = ~wr_ptr_q;
        end
        if (rd_pop) begin
          rd_ptr_d = ~rd_ptr_q;
          if (buf_last_q[rd_ptr_q]) state_d = S_IDLE;
        end
        cnt_d = cnt_q + {1'b0, out_q} - {1'b0, rd_pop};
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset aborts any burst and discards buffered read data.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      addr_q      <= '0;
      rem_q       <= '0;
      iss_done_q  <= 1'b0;
      out_q       <= 1'b0;
      out_last_q  <= 1'b0;
      buf_data_q  <= '{default: '0};
      buf_last_q  <= '{default: 1'b0};
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      cnt_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= (state_d == S_IDLE);
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      iss_done_q  <= iss_done_d;
      out_q       <= out_d;
      out_last_q  <= out_last_d;
      buf_data_q  <= buf_data_d;
      buf_last_q  <= buf_last_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule
